// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types and byte-level helpers.
// Used by the key schedule and the SubBytes/MixColumns round stages.
package aes_pkg;

    localparam int KEY_W      = 128;
    localparam int NUM_ROUNDS = 10;

    typedef logic [31:0]      aes_word_t;
    typedef logic [KEY_W-1:0] aes_key_t;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_EXPAND = 2'd1,
        KS_DONE   = 2'd2
    } ks_state_e;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = 11'd2047 - {b, 3'b000};
        return SBOX_TABLE[base -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);
    import aes_pkg::*;

    // Substitute every byte of the word independently.
    always_comb begin
        word_o = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            word_o[8*i +: 8] = sbox(word_i[8*i +: 8]);
        end
    end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: streams round keys 0..10 over valid/ready
// and keeps all of them in a store for reverse-order readback.
module aes_key_schedule #(
    parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS,
    parameter int KEY_W      = aes_pkg::KEY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk_data,
    output logic [3:0]       rk_idx,
    output logic             done,
    output logic             keys_avail,
    input  logic [3:0]       rd_idx,
    output logic [KEY_W-1:0] rd_key
);
    import aes_pkg::*;

    if (NUM_ROUNDS != 10 || KEY_W != 128) begin : g_unsupported
        $error("aes_key_schedule supports only AES-128 (NUM_ROUNDS=10, KEY_W=128)");
    end

    ks_state_e        state_q, state_d;
    logic [KEY_W-1:0] work_q, work_d;
    logic [KEY_W-1:0] store_q [0:NUM_ROUNDS];
    logic [KEY_W-1:0] store_d [0:NUM_ROUNDS];
    logic [3:0]       rk_idx_q, rk_idx_d;
    logic             rk_valid_q, rk_valid_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             keys_avail_q, keys_avail_d;

    logic [31:0]      rot_s;
    logic [31:0]      sub_s;
    logic [31:0]      t_s;
    logic [31:0]      w0_s, w1_s, w2_s, w3_s;
    logic [KEY_W-1:0] next_key_s;

    assign rot_s = {work_q[23:0], work_q[31:24]};

    aes_sub_word u_sub_word (
        .word_i (rot_s),
        .word_o (sub_s)
    );

    // One key-expansion step from the current working key and cnt's Rcon.
    always_comb begin
        t_s        = sub_s ^ {rcon(cnt_q), 24'h00_0000};
        w0_s       = work_q[127:96] ^ t_s;
        w1_s       = work_q[95:64]  ^ w0_s;
        w2_s       = work_q[63:32]  ^ w1_s;
        w3_s       = work_q[31:0]   ^ w2_s;
        next_key_s = {w0_s, w1_s, w2_s, w3_s};
    end

    // Next-state logic; a stalled handshake leaves every register unchanged.
    always_comb begin
        state_d      = state_q;
        work_d       = work_q;
        store_d      = store_q;
        rk_idx_d     = rk_idx_q;
        rk_valid_d   = rk_valid_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        keys_avail_d = keys_avail_q;
        case (state_q)
            KS_IDLE, KS_DONE: begin
                if (start) begin
                    state_d      = KS_EXPAND;
                    work_d       = key_in;
                    store_d[0]   = key_in;
                    rk_idx_d     = 4'd0;
                    rk_valid_d   = 1'b1;
                    cnt_d        = 4'd1;
                    busy_d       = 1'b1;
                    keys_avail_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            KS_EXPAND: begin
                if (rk_valid_q && rk_ready) begin
                    if (rk_idx_q == 4'(NUM_ROUNDS)) begin
                        state_d      = KS_DONE;
                        rk_valid_d   = 1'b0;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        keys_avail_d = 1'b1;
                    end else if (cnt_q <= 4'(NUM_ROUNDS)) begin
                        work_d         = next_key_s;
                        store_d[cnt_q] = next_key_s;
                        rk_idx_d       = cnt_q;
                        rk_valid_d     = 1'b1;
                        cnt_d          = cnt_q + 4'd1;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = KS_IDLE;
            end
        endcase
    end

    // State and key-store registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= KS_IDLE;
            work_q       <= '0;
            rk_idx_q     <= 4'd0;
            rk_valid_q   <= 1'b0;
            cnt_q        <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            keys_avail_q <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                store_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            work_q       <= work_d;
            rk_idx_q     <= rk_idx_d;
            rk_valid_q   <= rk_valid_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            keys_avail_q <= keys_avail_d;
            store_q      <= store_d;
        end
    end

    // Random-access readback; indices past the last round read as zero.
    always_comb begin
        if (rd_idx <= 4'(NUM_ROUNDS)) begin
            rd_key = store_q[rd_idx];
        end else begin
            rd_key = '0;
        end
    end

    // The streamed round key is the working key itself.
    assign rk_data    = work_q;
    assign rk_idx     = rk_idx_q;
    assign rk_valid   = rk_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_avail = keys_avail_q;

endmodule
